// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller: FSM states, line field
// offsets and the contents lines 0 and 1 take at reset.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    DONE      = 3'd4
  } state_t;

  // A line is packed as {valid, dirty, lru, tag, data}. Data sits at bit 0,
  // tag directly above it, and the three flags above the tag. Flag offsets
  // are relative to the first flag bit (ADDR_W + DATA_W).
  localparam int DATA_LSB  = 0;
  localparam int LRU_OFS   = 0;
  localparam int DIRTY_OFS = 1;
  localparam int VALID_OFS = 2;
  localparam int FLAG_W    = 3;

  // Reset image of line 0 and line 1; higher lines reset invalid.
  localparam logic [31:0] RST_TAG0  = 32'h04;
  localparam logic [31:0] RST_DATA0 = 32'h05;
  localparam logic [31:0] RST_TAG1  = 32'h05;
  localparam logic [31:0] RST_DATA1 = 32'h03;

endpackage

// File: rtl/seletor_vitima.sv
// Combinational hit detection and victim choice over all lines.
// Victim is the lowest-index invalid line, else the lowest-index line
// whose lru flag is clear.
module seletor_vitima
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LINES  = 2,
  parameter int IW     = 1
) (
  input  logic [LINES-1:0]             valid,
  input  logic [LINES-1:0]             lru,
  input  logic [LINES-1:0][ADDR_W-1:0] tags,
  input  logic [ADDR_W-1:0]            address,
  output logic                         hit,
  output logic [IW-1:0]                hit_idx,
  output logic [IW-1:0]                victim_idx
);

  logic          inv_found;
  logic [IW-1:0] inv_idx;
  logic [IW-1:0] old_idx;

  // Scan high to low so the lowest matching index wins each priority.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    inv_found  = 1'b0;
    inv_idx    = '0;
    old_idx    = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == address) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = IW'(i);
      end
      if (!lru[i]) old_idx = IW'(i);
    end
    victim_idx = inv_found ? inv_idx : old_idx;
  end

endmodule

// File: rtl/controlador_cache.sv
// Fully associative write-back cache controller with LRU-flag replacement
// and a single-request RAM port.
module controlador_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES  = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dataIn,
  output logic [DATA_W-1:0] cpu_dataOut,
  output logic              cpu_hit,
  output logic              cpu_done,
  output logic              busy,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  localparam int IW       = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int LW       = ADDR_W + DATA_W + FLAG_W;
  localparam int TAG_LSB  = DATA_LSB + DATA_W;
  localparam int FLAG_LSB = TAG_LSB + ADDR_W;
  localparam int LRU_B    = FLAG_LSB + LRU_OFS;
  localparam int DIRTY_B  = FLAG_LSB + DIRTY_OFS;
  localparam int VALID_B  = FLAG_LSB + VALID_OFS;

  typedef logic [LINES-1:0][LW-1:0] lines_t;

  state_t              state;
  lines_t              lines;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_data;
  logic [IW-1:0]       victim;

  logic [LINES-1:0]             valid_v, lru_v;
  logic [LINES-1:0][ADDR_W-1:0] tag_v;
  logic                         sel_hit;
  logic [IW-1:0]                sel_hit_idx, sel_victim;

  // Mark one line most recently used, all others not.
  function automatic lines_t touch(input lines_t l, input logic [IW-1:0] idx);
    lines_t r;
    r = l;
    for (int i = 0; i < LINES; i++) r[i][LRU_B] = (IW'(i) == idx);
    return r;
  endfunction

  // Place a tag/data pair in a line; any other copy of the tag is dropped.
  function automatic lines_t install(input lines_t l, input logic [IW-1:0] idx,
                                     input logic [ADDR_W-1:0] t,
                                     input logic [DATA_W-1:0] d, input logic drt);
    lines_t r;
    r = l;
    for (int i = 0; i < LINES; i++)
      if (IW'(i) != idx && r[i][TAG_LSB +: ADDR_W] == t) r[i][VALID_B] = 1'b0;
    r[idx][DATA_LSB +: DATA_W] = d;
    r[idx][TAG_LSB +: ADDR_W]  = t;
    r[idx][VALID_B]            = 1'b1;
    r[idx][DIRTY_B]            = drt;
    return touch(r, idx);
  endfunction

  function automatic lines_t write_hit(input lines_t l, input logic [IW-1:0] idx,
                                       input logic [DATA_W-1:0] d);
    lines_t r;
    r = l;
    r[idx][DATA_LSB +: DATA_W] = d;
    r[idx][DIRTY_B]            = 1'b1;
    return touch(r, idx);
  endfunction

  function automatic lines_t reset_lines();
    lines_t r;
    r = '0;
    for (int i = 0; i < LINES; i++) begin
      if (i == 0) begin
        r[i][VALID_B]              = 1'b1;
        r[i][TAG_LSB +: ADDR_W]    = ADDR_W'(RST_TAG0);
        r[i][DATA_LSB +: DATA_W]   = DATA_W'(RST_DATA0);
      end else if (i == 1) begin
        r[i][VALID_B]              = 1'b1;
        r[i][LRU_B]                = 1'b1;
        r[i][TAG_LSB +: ADDR_W]    = ADDR_W'(RST_TAG1);
        r[i][DATA_LSB +: DATA_W]   = DATA_W'(RST_DATA1);
      end
    end
    return r;
  endfunction

  // Unpack the fields the selector needs.
  always_comb begin
    valid_v = '0;
    lru_v   = '0;
    tag_v   = '0;
    for (int i = 0; i < LINES; i++) begin
      valid_v[i] = lines[i][VALID_B];
      lru_v[i]   = lines[i][LRU_B];
      tag_v[i]   = lines[i][TAG_LSB +: ADDR_W];
    end
  end

  seletor_vitima #(.ADDR_W(ADDR_W), .LINES(LINES), .IW(IW)) u_sel (
    .valid      (valid_v),
    .lru        (lru_v),
    .tags       (tag_v),
    .address    (req_addr),
    .hit        (sel_hit),
    .hit_idx    (sel_hit_idx),
    .victim_idx (sel_victim)
  );

  // Controller FSM; every output is registered and busy tracks state != IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      lines       <= reset_lines();
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_data    <= '0;
      victim      <= '0;
      cpu_dataOut <= '0;
      cpu_hit     <= 1'b0;
      cpu_done    <= 1'b0;
      busy        <= 1'b0;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          req_write <= cpu_write;
          req_addr  <= cpu_address;
          req_data  <= cpu_dataIn;
          busy      <= 1'b1;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          cpu_hit <= sel_hit;
          victim  <= sel_victim;
          if (sel_hit) begin
            if (req_write) lines <= write_hit(lines, sel_hit_idx, req_data);
            else begin
              cpu_dataOut <= lines[sel_hit_idx][DATA_LSB +: DATA_W];
              lines       <= touch(lines, sel_hit_idx);
            end
            state <= DONE;
          end else if (lines[sel_victim][VALID_B] && lines[sel_victim][DIRTY_B]) begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= lines[sel_victim][TAG_LSB +: ADDR_W];
            ram_wdata <= lines[sel_victim][DATA_LSB +: DATA_W];
            state     <= WRITEBACK;
          end else if (req_write) begin
            lines <= install(lines, sel_victim, req_addr, req_data, 1'b1);
            state <= DONE;
          end else begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= req_addr;
            state    <= FILL;
          end
        end
        WRITEBACK: if (ram_ack) begin
          ram_we <= 1'b0;
          if (req_write) begin
            // The victim is cleaned and immediately overwritten by the install.
            lines   <= install(lines, victim, req_addr, req_data, 1'b1);
            ram_req <= 1'b0;
            state   <= DONE;
          end else begin
            lines[victim][DIRTY_B] <= 1'b0;
            ram_addr <= req_addr;
            state    <= FILL;
          end
        end
        FILL: if (ram_ack) begin
          lines       <= install(lines, victim, req_addr, ram_rdata, 1'b0);
          cpu_dataOut <= ram_rdata;
          ram_req     <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          cpu_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/controlador_cache.md
CONTROLADOR_CACHE -- requirements
Module: controlador_cache

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 8, word width; LINES, default 2, number of fully associative lines.
REQ-002 clock  input  1  sole clock; all state SHALL change on posedge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  access request, sampled only in IDLE.
REQ-005 cpu_write  input  1  1 = write, 0 = read.
REQ-006 cpu_address  input  ADDR_W  access address, also the tag.
REQ-007 cpu_dataIn  input  DATA_W  write data.
REQ-008 cpu_dataOut  output  DATA_W  read data, held until the next completion.
REQ-009 cpu_hit  output  1  1 = last access hit, 0 = miss, held until the next completion.
REQ-010 cpu_done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 ram_req, ram_we  output  1 each  RAM request strobe and write enable.
REQ-013 ram_addr, ram_wdata  output  ADDR_W, DATA_W  RAM address and write data.
REQ-014 ram_rdata, ram_ack  input  DATA_W, 1  RAM read data and completion strobe.

Function
REQ-015 Each line SHALL hold valid, dirty, lru, tag[ADDR_W] and data[DATA_W]; the block owns this storage.
REQ-016 The FSM SHALL have states IDLE, LOOKUP, WRITEBACK, FILL, DONE, with one transition per clock.
REQ-017 IDLE: when cpu_req=1, the FSM SHALL capture write/address/dataIn and go to LOOKUP; while busy=1, cpu_req SHALL be ignored.
REQ-018 LOOKUP hit (valid and tag==address): a read SHALL load cpu_dataOut; a write SHALL update data and set dirty=1; cpu_hit SHALL be set to 1; next state SHALL be DONE.
REQ-019 LOOKUP miss: the victim SHALL be the lowest-index invalid line, else the line with lru=0; cpu_hit SHALL be set to 0.
REQ-020 Miss routing: a valid and dirty victim SHALL go to WRITEBACK; otherwise a read SHALL go to FILL and a write SHALL install the line (tag, data, valid=1, dirty=1) and go to DONE.
REQ-021 WRITEBACK: ram_req=1, ram_we=1, ram_addr=victim tag, ram_wdata=victim data, held until ram_ack=1; on ack the victim SHALL become clean, then a read SHALL go to FILL and a write SHALL install and go to DONE.
REQ-022 FILL: ram_req=1, ram_we=0, ram_addr=captured address until ram_ack; on ack the victim SHALL be loaded with tag, ram_rdata, valid=1, dirty=0, cpu_dataOut SHALL take ram_rdata, and the FSM SHALL go to DONE.
REQ-023 ram_ack in the first request cycle (zero wait) SHALL be accepted; ram_ack outside WRITEBACK/FILL SHALL be ignored; ram_req SHALL be 0 in IDLE, LOOKUP and DONE.
REQ-024 LRU: the line accessed (hit, fill or install) SHALL get lru=1 and all other lines lru=0.
REQ-025 DONE: cpu_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 Hit latency: with cpu_req sampled at edge T, cpu_done SHALL be high in the cycle after edge T+2.
REQ-027 Miss latency SHALL be the hit latency plus the RAM wait cycles of each phase.
REQ-028 Two lines holding the same tag SHALL never both be valid; an install SHALL invalidate any other line with that tag.

Reset
REQ-029 Asserting resetn=0 SHALL immediately force IDLE, ram_req=0, ram_we=0, cpu_done=0, cpu_hit=0, cpu_dataOut=0, busy=0, ram_addr=0 and ram_wdata=0.
REQ-030 Reset SHALL load line0 as {valid=1, dirty=0, lru=0, tag=0x04, data=0x05} and line1 as {valid=1, dirty=0, lru=1, tag=0x05, data=0x03}; lines at index 2 and above SHALL be reset invalid.
REQ-031 Reset during an operation SHALL abandon it; dirty data is lost and no completion pulse is issued.

Structure
REQ-032 State encoding, line field offsets and reset line constants SHALL reside in shared package cache_pkg.
REQ-033 Hit detection and victim selection SHALL be a combinational sub-module seletor_vitima.

Verification
REQ-034 After reset, read 0x04 -> cpu_done at T+2, cpu_hit=1, cpu_dataOut=0x05, no ram_req.
REQ-035 Then read 0x20 with ram_rdata=0xAB acked after 3 cycles -> victim line1, FILL with ram_addr=0x20, no RAM write, cpu_dataOut=0xAB, cpu_hit=0.
REQ-036 After reset, write 0x04/0x77 -> hit with no RAM traffic; write 0x30/0x11 -> clean victim line1 installed, no RAM traffic; write 0x40/0x22 -> WRITEBACK with ram_addr=0x04, ram_wdata=0x77, ram_we=1, then install with no FILL.
REQ-037 resetn pulsed low during FILL (ram_ack held low) -> ram_req falls immediately; a later read of 0x05 hits and returns 0x03.
REQ-038 cpu_req pulsed while busy=1 and ram_ack pulsed in IDLE -> both ignored, no extra cpu_done and no state change.
